pwm_ramp_sequencer: RTL and testbench



---
 rtl/pwm_ramp_sequencer.sv | 126 ++++++++++++
 tb/tb_pwm_ramp_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_ramp_sequencer.sv
// ============================================================================
// Module   : pwm_ramp_sequencer
// Brief    : Walks the PWM duty toward a commanded target, one step per dwell,
//            updating only on PWM period boundaries.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pwm_ramp_sequencer #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4,
    parameter int HOLD_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pwm_en,
    input  logic [WIDTH-1:0]  pwm_count,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [WIDTH-1:0]  cmd_target,
    input  logic [STEP_W-1:0] cmd_step,
    input  logic [HOLD_W-1:0] cmd_hold,
    input  logic              abort,
    output logic [WIDTH-1:0]  duty_cycle,
    output logic              busy,
    output logic              done,
    output logic              aborted
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RAMP = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] c_all_ones = '1;

    state_t              r_state;
    logic [WIDTH-1:0]    r_duty;
    logic [WIDTH-1:0]    r_target;
    logic [STEP_W-1:0]   r_step;
    logic [HOLD_W-1:0]   r_hold;
    logic [HOLD_W-1:0]   r_dwell;
    logic                r_done;
    logic                r_aborted;

    logic                     w_boundary;
    logic [STEP_W-1:0]        w_cmd_step;
    logic [HOLD_W-1:0]        w_cmd_hold;
    logic [HOLD_W-1:0]        w_dwell_dec;
    logic [WIDTH:0]           w_sum;
    logic signed [WIDTH+1:0]  w_diff;
    logic [WIDTH-1:0]         w_up_next;
    logic [WIDTH-1:0]         w_dn_next;
    logic [WIDTH-1:0]         w_next_duty;

    // The counter wraps to 0 on the edge after all-ones, so updating here
    // makes the new duty apply to a whole fresh period.
    assign w_boundary  = pwm_en && (pwm_count == c_all_ones);

    assign w_cmd_step  = (cmd_step == '0) ? STEP_W'(1) : cmd_step;
    assign w_cmd_hold  = (cmd_hold == '0) ? HOLD_W'(1) : cmd_hold;
    assign w_dwell_dec = r_dwell - HOLD_W'(1);

    // One extra bit up and a signed two-bit-wider difference down keep the
    // step from wrapping past either end before the clamp to target.
    assign w_sum       = {1'b0, r_duty} + (WIDTH+1)'(r_step);
    assign w_diff      = $signed({2'b00, r_duty}) - $signed((WIDTH+2)'(r_step));
    assign w_up_next   = (w_sum > {1'b0, r_target}) ? r_target : w_sum[WIDTH-1:0];
    assign w_dn_next   = (w_diff < $signed({2'b00, r_target})) ? r_target
                                                               : w_diff[WIDTH-1:0];
    assign w_next_duty = (r_duty < r_target) ? w_up_next : w_dn_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_duty    <= '0;
            r_target  <= '0;
            r_step    <= '0;
            r_hold    <= '0;
            r_dwell   <= '0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            if (r_state == S_IDLE) begin
                if (cmd_valid) begin
                    r_target <= cmd_target;
                    r_step   <= w_cmd_step;
                    r_hold   <= w_cmd_hold;
                    if (cmd_target == r_duty) begin
                        r_done <= 1'b1;
                    end else begin
                        r_state <= S_RAMP;
                        r_dwell <= w_cmd_hold;
                    end
                end
            end else begin
                if (abort) begin
                    r_state   <= S_IDLE;
                    r_aborted <= 1'b1;
                end else if (w_boundary) begin
                    if (w_dwell_dec == '0) begin
                        r_duty  <= w_next_duty;
                        r_dwell <= r_hold;
                        if (w_next_duty == r_target) begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_dwell <= w_dwell_dec;
                    end
                end
            end
        end
    end

    assign cmd_ready  = (r_state == S_IDLE);
    assign busy       = (r_state == S_RAMP);
    assign duty_cycle = r_duty;
    assign done       = r_done;
    assign aborted    = r_aborted;

endmodule

`default_nettype wire

// File: tb/tb_pwm_ramp_sequencer.sv
// ============================================================================
// Module   : tb_pwm_ramp_sequencer
// Brief    : Directed and random ramp commands checked against a sequence model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pwm_ramp_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       pwm_en;
    logic [7:0] pwm_count;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_target;
    logic [3:0] cmd_step;
    logic [7:0] cmd_hold;
    logic       abort;
    logic [7:0] duty_cycle;
    logic       busy;
    logic       done;
    logic       aborted;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] m_duty = 8'h00;

    pwm_ramp_sequencer #(.WIDTH(8), .STEP_W(4), .HOLD_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .pwm_en     (pwm_en),
        .pwm_count  (pwm_count),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_target (cmd_target),
        .cmd_step   (cmd_step),
        .cmd_hold   (cmd_hold),
        .abort      (abort),
        .duty_cycle (duty_cycle),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: a boundary when asked, otherwise a random non-boundary pattern.
    task automatic tick(input bit bnd, input bit ab);
        abort = ab;
        if (bnd) begin
            pwm_en    = 1'b1;
            pwm_count = 8'hFF;
        end else if ($urandom_range(0, 1) == 0) begin
            pwm_en    = 1'b0;
            pwm_count = 8'($urandom);
        end else begin
            pwm_en    = 1'b1;
            pwm_count = 8'($urandom_range(0, 254));
        end
        @(posedge clk);
        #1;
        abort = 1'b0;
    endtask

    // act: 0 none, 1 abort on a boundary, 2 async reset, 3 long pwm_en=0 stall;
    // applied once act_k updates have happened.
    task automatic run_ramp(input logic [7:0] t, input logic [3:0] s, input logic [7:0] h,
                            input int act, input int act_k, input bit pend,
                            input logic [7:0] pt, input logic [3:0] ps, input logic [7:0] ph,
                            input int pbnd);
        int seq[$];
        int d, se, he, nb, k, cyc, cur;
        bit bnd, upd;
        se = (s == 0) ? 1 : int'(s);
        he = (h == 0) ? 1 : int'(h);
        d  = int'(m_duty);
        while (d != int'(t)) begin
            if (d < int'(t)) d = (d + se > int'(t)) ? int'(t) : d + se;
            else             d = (d - se < int'(t)) ? int'(t) : d - se;
            seq.push_back(d);
        end

        chk("ready_pre", 32'(cmd_ready), 32'd1);
        cmd_valid  = 1'b1;
        cmd_target = t;
        cmd_step   = s;
        cmd_hold   = h;
        tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        if (pend) begin
            cmd_target = pt;
            cmd_step   = ps;
            cmd_hold   = ph;
        end else begin
            cmd_valid = 1'b0;
        end

        if (seq.size() == 0) begin
            chk("noop_done", 32'(done), 32'd1);
            chk("noop_busy", 32'(busy), 32'd0);
            chk("noop_duty", 32'(duty_cycle), 32'(m_duty));
            chk("noop_aborted", 32'(aborted), 32'd0);
            tick(1'b1, 1'b0);
            chk("noop_done_pulse", 32'(done), 32'd0);
            chk("noop_busy2", 32'(busy), 32'd0);
            return;
        end

        chk("acc_busy", 32'(busy), 32'd1);
        chk("acc_done", 32'(done), 32'd0);
        chk("acc_duty", 32'(duty_cycle), 32'(m_duty));
        nb  = 0;
        k   = 0;
        cyc = 0;
        while (k < seq.size()) begin
            cur = (k == 0) ? int'(m_duty) : seq[k-1];
            if (act == 1 && k == act_k) begin
                tick(1'b1, 1'b1);
                chk("abort_duty", 32'(duty_cycle), 32'(cur));
                chk("abort_pulse", 32'(aborted), 32'd1);
                chk("abort_done", 32'(done), 32'd0);
                chk("abort_busy", 32'(busy), 32'd0);
                m_duty = 8'(cur);
                tick(1'b1, 1'b0);
                chk("abort_pulse_end", 32'(aborted), 32'd0);
                chk("abort_ready", 32'(cmd_ready), 32'd1);
                chk("abort_duty2", 32'(duty_cycle), 32'(cur));
                return;
            end
            if (act == 2 && k == act_k) begin
                #2 rst = 1'b1;
                #1;
                chk("rst_duty", 32'(duty_cycle), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_ready", 32'(cmd_ready), 32'd1);
                chk("rst_done", 32'(done), 32'd0);
                m_duty = 8'h00;
                @(negedge clk);
                rst = 1'b0;
                @(posedge clk);
                #1;
                return;
            end
            if (act == 3 && k == act_k) begin
                repeat (1000) begin
                    pwm_en    = 1'b0;
                    pwm_count = 8'($urandom);
                    @(posedge clk);
                end
                #1;
                chk("stall_duty", 32'(duty_cycle), 32'(cur));
                chk("stall_busy", 32'(busy), 32'd1);
                act = 0;
            end
            if (cyc > 20000) begin
                checks++;
                errors++;
                $error("FAIL timeout observed=%0d expected=%0d", k, seq.size());
                break;
            end
            bnd = ($urandom_range(0, 99) < pbnd);
            tick(bnd, 1'b0);
            cyc++;
            upd = 1'b0;
            if (bnd) begin
                nb++;
                if (nb == (k + 1) * he) begin
                    k++;
                    upd = 1'b1;
                end
            end
            chk("duty", 32'(duty_cycle), 32'((k == 0) ? int'(m_duty) : seq[k-1]));
            chk("done", 32'(done), 32'(upd && k == seq.size()));
            chk("busy", 32'(busy), 32'(k < seq.size()));
            chk("ready", 32'(cmd_ready), 32'(k == seq.size()));
            chk("aborted", 32'(aborted), 32'd0);
        end
        m_duty = 8'(seq[$]);
    endtask

    initial begin
        rst        = 1'b1;
        pwm_en     = 1'b0;
        pwm_count  = 8'h00;
        cmd_valid  = 1'b0;
        cmd_target = 8'h00;
        cmd_step   = 4'h0;
        cmd_hold   = 8'h00;
        abort      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_duty", 32'(duty_cycle), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_aborted", 32'(aborted), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_ready", 32'(cmd_ready), 32'd1);

        run_ramp(8'h10, 4'd4,  8'd1, 0, 0, 1'b0, 8'h00, 4'd0, 8'd0, 100);
        run_ramp(8'hFC, 4'hF,  8'd1, 0, 0, 1'b0, 8'h00, 4'd0, 8'd0, 60);
        run_ramp(8'hFF, 4'hF,  8'd1, 0, 0, 1'b0, 8'h00, 4'd0, 8'd0, 60);
        run_ramp(8'h10, 4'hF,  8'd3, 0, 0, 1'b0, 8'h00, 4'd0, 8'd0, 60);
        run_ramp(8'h00, 4'hF,  8'd2, 0, 0, 1'b0, 8'h00, 4'd0, 8'd0, 60);
        run_ramp(8'h80, 4'd1,  8'd1, 1, 5, 1'b0, 8'h00, 4'd0, 8'd0, 70);
        run_ramp(8'h20, 4'd3,  8'd2, 0, 0, 1'b1, 8'h28, 4'd0, 8'd1, 60);
        run_ramp(8'h28, 4'd0,  8'd1, 0, 0, 1'b0, 8'h00, 4'd0, 8'd0, 60);
        run_ramp(8'h60, 4'd2,  8'd2, 3, 3, 1'b0, 8'h00, 4'd0, 8'd0, 60);
        run_ramp(m_duty, 4'd5, 8'd1, 0, 0, 1'b0, 8'h00, 4'd0, 8'd0, 60);
        run_ramp(8'h00, 4'hF,  8'd0, 0, 0, 1'b0, 8'h00, 4'd0, 8'd0, 80);
        run_ramp(8'h80, 4'h0,  8'd1, 2, 4, 1'b0, 8'h00, 4'd0, 8'd0, 100);

        repeat (25) begin
            logic [7:0] rt;
            rt = ($urandom_range(0, 7) == 0) ? m_duty : 8'($urandom);
            run_ramp(rt, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 2)),
                     ($urandom_range(0, 5) == 0) ? 1 : 0, $urandom_range(0, 6),
                     1'b0, 8'h00, 4'd0, 8'd0, 50);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
